data_memory_responder: RTL and testbench

Word-addressed data memory that acts as the responder end of the CPU's load/store port. It accepts one request at a time over a valid/ready request channel and returns the result over a valid/ready response channel after a configurable number of wait states. It supports byte-lane write strobes and flags misaligned or out-of-range accesses. It sits behind the core's memory stage and replaces a zero-latency data array when the datapath moves to multi-cycle memory access.

---
 rtl/data_memory_responder.sv | 138 +++++++++++++
 tb/tb_data_memory_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Word-addressed data memory acting as the responder of a valid/ready load/store port.
// One request in flight; the access happens LATENCY cycles after accept and the result is held until taken.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy
);
    localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic            do_acc, accept, mem_we;
    logic            acc_write, acc_err;
    logic [31:0]     acc_addr, acc_wdata;
    logic [3:0]      acc_wstrb;
    logic [IDXW-1:0] acc_idx;

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_error = err_q;

    assign accept = (state_q == S_IDLE) && req_valid;

    // With zero wait states the access uses the live request fields at the accept edge.
    assign acc_write = (state_q == S_IDLE) ? req_write : wr_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign acc_wstrb = (state_q == S_IDLE) ? req_wstrb : wstrb_q;
    assign acc_idx   = acc_addr[IDXW+1:2];
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign mem_we    = do_acc && acc_write && !acc_err;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        do_acc       = 1'b0;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        do_acc  = 1'b1;
                        state_d = S_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    do_acc  = 1'b1;
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_acc) begin
            resp_valid_d = 1'b1;
            err_d        = acc_err;
            rdata_d      = (acc_err || acc_write) ? 32'h0 : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    // Reset wins over a store committing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: LATENCY=2 instance for function/backpressure/reset, LATENCY=0 instance for throughput.
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error, busy;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    logic        rst0, req_valid0, req_ready0, req_write0, resp_valid0, resp_ready0, resp_error0, busy0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic [3:0]  req_wstrb0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .busy(busy)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .reset(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0),
        .resp_error(resp_error0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance with resp_ready held high.
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] exp_rd, input logic exp_err);
        int cyc;
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd3);
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(resp_error), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_done"}, 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] l0_addr [8];
    logic [31:0] l0_wd   [8];
    logic [3:0]  l0_st   [8];
    logic        l0_wr   [8];
    logic [31:0] l0_exp  [8];

    initial begin
        int cyc;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b1;
        rst0 = 1'b1; req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wstrb0 = '0;
        resp_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; rst0 = 1'b0;

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_error), 32'd0);

        xact("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        xact("ld_full", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
        xact("st_part", 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        xact("ld_part", 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDE22BE44, 1'b0);
        xact("st_nostrb", 1'b1, 32'h10, 32'h55555555, 4'b0000, 32'h0, 1'b0);
        xact("ld_nostrb", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22BE44, 1'b0);
        xact("ld_misal", 1'b0, 32'h12, 32'h0, 4'b0000, 32'h0, 1'b1);
        xact("st_oor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
        xact("ld_w0", 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
        xact("ld_last", 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'h0, 1'b0);

        // Backpressure: load held in RESP while a store waits on the request channel.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'b0000;
        @(posedge clk); #1;
        req_write = 1'b1; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'b1111;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_lat", 32'(cyc), 32'd3);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'hDE22BE44);
            chk("bp_err", 32'(resp_error), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_valid", 32'(resp_valid), 32'd0);
        chk("bp_rel_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        chk("bp_2nd_busy", 32'(busy), 32'd1);
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_2nd_lat", 32'(cyc), 32'd3);
        chk("bp_2nd_err", 32'(resp_error), 32'd0);
        @(posedge clk); #1;
        xact("ld_after_bp", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hFFFFFFFF, 1'b0);

        // Reset lands on the commit edge of an in-flight store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'b1111;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_ready", 32'(req_ready), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rvalid", 32'(resp_valid), 32'd0);
        chk("mid_rdata", resp_rdata, 32'h0);
        chk("mid_err", 32'(resp_error), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("mid_noresp", 32'(resp_valid), 32'd0);
        end
        xact("ld_dropped", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h0, 1'b0);
        xact("ld_cleared", 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);

        // Zero-latency instance: continuous requests, one accept every 2 cycles.
        l0_wr[0] = 1'b1; l0_addr[0] = 32'h40;  l0_wd[0] = 32'h01234567; l0_st[0] = 4'b1111; l0_exp[0] = 32'h0;
        l0_wr[1] = 1'b0; l0_addr[1] = 32'h40;  l0_wd[1] = 32'h0;        l0_st[1] = 4'b0000; l0_exp[1] = 32'h01234567;
        l0_wr[2] = 1'b1; l0_addr[2] = 32'h44;  l0_wd[2] = 32'h89ABCDEF; l0_st[2] = 4'b0011; l0_exp[2] = 32'h0;
        l0_wr[3] = 1'b0; l0_addr[3] = 32'h44;  l0_wd[3] = 32'h0;        l0_st[3] = 4'b0000; l0_exp[3] = 32'h0000CDEF;
        l0_wr[4] = 1'b1; l0_addr[4] = 32'h40;  l0_wd[4] = 32'h5A5A5A5A; l0_st[4] = 4'b1000; l0_exp[4] = 32'h0;
        l0_wr[5] = 1'b0; l0_addr[5] = 32'h40;  l0_wd[5] = 32'h0;        l0_st[5] = 4'b0000; l0_exp[5] = 32'h5A234567;
        l0_wr[6] = 1'b1; l0_addr[6] = 32'h3FC; l0_wd[6] = 32'h13579BDF; l0_st[6] = 4'b1111; l0_exp[6] = 32'h0;
        l0_wr[7] = 1'b0; l0_addr[7] = 32'h3FC; l0_wd[7] = 32'h0;        l0_st[7] = 4'b0000; l0_exp[7] = 32'h13579BDF;
        req_valid0 = 1'b1;
        req_write0 = l0_wr[0]; req_addr0 = l0_addr[0]; req_wdata0 = l0_wd[0]; req_wstrb0 = l0_st[0];
        for (int k = 0; k < 8; k++) begin
            chk("l0_accept", 32'(req_ready0), 32'd1);
            @(posedge clk); #1;
            chk("l0_valid", 32'(resp_valid0), 32'd1);
            chk("l0_ready_lo", 32'(req_ready0), 32'd0);
            chk("l0_rdata", resp_rdata0, l0_exp[k]);
            chk("l0_err", 32'(resp_error0), 32'd0);
            if (k < 7) begin
                req_write0 = l0_wr[k+1]; req_addr0 = l0_addr[k+1];
                req_wdata0 = l0_wd[k+1]; req_wstrb0 = l0_st[k+1];
            end else begin
                req_valid0 = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("l0_idle", 32'(busy0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
